if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipeline CPU; the producer side of the IF/ID pipeline register.
- Owns the PC and addresses instruction memory (combinational read).
- Presents if_pc, if_pc4 and if_inst to IF/ID.
- Generates the flush that converts IF/ID contents into a NOP bubble after a taken branch or jump (redirect) arrives from EX.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 10, instruction-memory word-address width (1024 words).
- FLUSH_CYCLES, 1, number of consecutive cycles flush is held per redirect (1..4).

Ports:
- ram_clk  in  1  pipeline clock.
- rst_n  in  1  reset, synchronous, active-low.
- stall  in  1  hazard unit: hold PC and outputs.
- redirect_valid  in  1  EX: taken branch/jump this cycle.
- redirect_pc  in  32  EX: target address.
- imem_addr  out  IMEM_AW  word address to instruction ROM, equal to pc[IMEM_AW+1:2].
- imem_rdata  in  32  instruction word; combinational, same cycle.
- if_pc  out  32  current PC.
- if_pc4  out  32  if_pc + 4.
- if_inst  out  32  fetched instruction, or NOP while not issuing.
- if_valid  out  1  this cycle's if_inst is a real instruction.
- flush  out  1  to IF/ID: load bubble.
- misalign_err  out  1  sticky: a redirect target had bit[1:0] != 0.
- fetch_count  out  32  instructions issued since reset.

Behaviour:
- All state updates on posedge ram_clk. Reset is synchronous: rst_n=0 at an edge loads the reset values, including mid-redirect and mid-flush.
- Reset values:
  - pc = RESET_PC, state = BOOT, flush_cnt = 0, misalign_err = 0, fetch_count = 0.
  - Outputs during BOOT: if_inst = NOP (32'h0000_0033), if_valid = 0, flush = 0.
- FSM states:
  - BOOT: exactly one cycle after reset release, with no PC advance. Next state is RUN. A redirect arriving in BOOT is taken as in RUN.
  - RUN: normal fetch.
  - FLUSH: entered when FLUSH_CYCLES > 1 after a redirect; stays FLUSH_CYCLES-1 cycles, then returns to RUN.
- Combinational outputs:
  - if_pc = pc.
  - if_pc4 = pc + 32'd4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - if_inst = imem_rdata when if_valid, else NOP.
  - if_valid = (state==RUN) && !flush.
  - flush = redirect_valid || (state==FLUSH).
- PC update priority, highest first:
  1. redirect_valid: pc <= {redirect_pc[31:2], 2'b00}. If redirect_pc[1:0] != 0, set misalign_err (sticky until reset). If FLUSH_CYCLES > 1, state <= FLUSH and flush_cnt <= FLUSH_CYCLES-2; otherwise state <= RUN.
  2. state==FLUSH: pc holds. flush_cnt decrements; at 0, state <= RUN.
  3. stall: pc holds.
  4. RUN: pc <= pc + 4 (wraps).
- Redirect always beats stall: the wrong-path instruction is discarded even while stalled.
- A redirect during FLUSH restarts the flush window with the new target.
- flush_cnt decrements regardless of stall.
- fetch_count increments by 1 when if_valid && !stall. It saturates at 32'hFFFF_FFFF.
- imem_addr is pc[IMEM_AW+1:2]. Upper PC bits beyond IMEM_AW+2 are ignored, so the address aliases.
- Latency: redirect to first fetch at the target is 1 cycle, plus FLUSH_CYCLES-1.

Decomposition:
- Shared package cpu_pkg holds: XLEN=32, NOP_INST=32'h0000_0033, and the fetch-state encoding (BOOT, RUN, FLUSH) as a typedef/localparams. The IF/ID register's bubble constant is taken from the same package.
- One natural sub-module: if_flush_ctrl. It contains the FSM and flush_cnt, takes redirect_valid, and produces flush, state and pc_hold.
- PC register, adder and counters stay in the top module.

Test Plan:
- Reset then run, no stall/redirect, RESET_PC=0: BOOT cycle shows if_valid=0, if_inst=0x33. Then if_pc = 0, 4, 8, 12 with if_pc4 = 4, 8, 12, 16. After 4 issues, fetch_count=4.
- stall=1 for 3 cycles at pc=0x10: if_pc stays 0x10, if_inst stays constant, fetch_count stays frozen. Release gives pc=0x14 next cycle.
- redirect_valid=1, redirect_pc=0x100 at pc=0x20, FLUSH_CYCLES=1: flush=1 and if_valid=0 that cycle. Next cycle if_pc=0x100, flush=0, if_valid=1.
- FLUSH_CYCLES=3, redirect to 0x40 together with stall=1: flush is high 3 consecutive cycles. pc=0x40 is held throughout, then RUN resumes. Second redirect to 0x80 in the 2nd flush cycle restarts a 3-cycle window at 0x80.
- redirect_pc=0x0000_0106: pc becomes 0x104 and misalign_err=1, remaining 1 across later redirects until rst_n=0.
- pc=0xFFFF_FFFC: if_pc4=0. Next pc=0 and imem_addr=0. rst_n=0 asserted mid-FLUSH returns pc=RESET_PC, flush=0 and misalign_err=0 on the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: data width, the NOP bubble word and the fetch-stage state encoding.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  // add x0,x0,x0 -- also the IF/ID register's bubble value
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0033;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_flush_ctrl.sv
// Fetch-stage sequencer: one BOOT cycle after reset, then RUN, with a FLUSH window
// of FLUSH_CYCLES total bubble cycles per redirect (the redirect cycle counts as the first).
module if_flush_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic         ram_clk,
  input  logic         rst_n,
  input  logic         redirect_valid,
  output fetch_state_e state,
  output logic         flush,
  output logic         pc_hold
);

  // Countdown preload for the FLUSH state; only meaningful when FLUSH_CYCLES > 1
  localparam logic [1:0] CNT_INIT = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

  fetch_state_e state_q, state_d;
  logic [1:0]   flush_cnt_q, flush_cnt_d;

  always_ff @(posedge ram_clk) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (redirect_valid) begin
      // A redirect always (re)starts the window, whatever state we are in
      if (FLUSH_CYCLES > 1) begin
        state_d     = ST_FLUSH;
        flush_cnt_d = CNT_INIT;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      unique case (state_q)
        ST_BOOT:  state_d = ST_RUN;
        ST_FLUSH: begin
          if (flush_cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 2'd1;
          end
        end
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    state   = state_q;
    flush   = redirect_valid || (state_q == ST_FLUSH);
    pc_hold = (state_q != ST_RUN);
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and feeds the IF/ID register.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_AW      = 10,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic               ram_clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic [XLEN-1:0]    if_pc,
  output logic [XLEN-1:0]    if_pc4,
  output logic [XLEN-1:0]    if_inst,
  output logic               if_valid,
  output logic               flush,
  output logic               misalign_err,
  output logic [XLEN-1:0]    fetch_count
);

  fetch_state_e    state;
  logic            pc_hold;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_err_q, misalign_err_d;
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;

  if_flush_ctrl #(
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) u_flush_ctrl (
    .ram_clk        (ram_clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .state          (state),
    .flush          (flush),
    .pc_hold        (pc_hold)
  );

  always_ff @(posedge ram_clk) begin
    if (!rst_n) begin
      pc_q           <= RESET_PC;
      misalign_err_q <= 1'b0;
      fetch_count_q  <= '0;
    end else begin
      pc_q           <= pc_d;
      misalign_err_q <= misalign_err_d;
      fetch_count_q  <= fetch_count_d;
    end
  end

  always_comb begin
    if_pc4   = pc_q + 32'd4;
    if_valid = (state == ST_RUN) && !flush;

    // Redirect outranks both the flush hold and a hazard stall
    pc_d           = pc_q;
    misalign_err_d = misalign_err_q;
    if (redirect_valid) begin
      pc_d           = {redirect_pc[XLEN-1:2], 2'b00};
      misalign_err_d = misalign_err_q || (redirect_pc[1:0] != 2'b00);
    end else if (!pc_hold && !stall) begin
      pc_d = if_pc4;
    end

    fetch_count_d = fetch_count_q;
    if (if_valid && !stall && (fetch_count_q != '1)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_comb begin
    imem_addr    = pc_q[IMEM_AW+1:2];
    if_pc        = pc_q;
    if_inst      = if_valid ? imem_rdata : NOP_INST;
    misalign_err = misalign_err_q;
    fetch_count  = fetch_count_q;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: two instances (FLUSH_CYCLES=1 and 3) on shared stimulus,
// a directed table, hand sequences and random traffic against a behavioural model.
module tb_if_fetch_unit;
  import cpu_pkg::*;

  localparam int unsigned AW = 10;

  logic ram_clk = 1'b0;
  always #5 ram_clk = ~ram_clk;

  logic        rst_n, stall, redirect_valid;
  logic [31:0] redirect_pc;

  logic [AW-1:0] o_addr [2];
  logic [31:0]   rdata  [2];
  logic [31:0]   o_pc   [2];
  logic [31:0]   o_pc4  [2];
  logic [31:0]   o_inst [2];
  logic          o_valid[2];
  logic          o_flush[2];
  logic          o_err  [2];
  logic [31:0]   o_cnt  [2];

  function automatic logic [31:0] inst_of(input logic [AW-1:0] a);
    return {6'h2A, a, 6'h15, a};
  endfunction

  assign rdata[0] = inst_of(o_addr[0]);
  assign rdata[1] = inst_of(o_addr[1]);

  if_fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(AW), .FLUSH_CYCLES(1)) dut1 (
    .ram_clk(ram_clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(o_addr[0]), .imem_rdata(rdata[0]),
    .if_pc(o_pc[0]), .if_pc4(o_pc4[0]), .if_inst(o_inst[0]), .if_valid(o_valid[0]),
    .flush(o_flush[0]), .misalign_err(o_err[0]), .fetch_count(o_cnt[0]));

  if_fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(AW), .FLUSH_CYCLES(3)) dut3 (
    .ram_clk(ram_clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(o_addr[1]), .imem_rdata(rdata[1]),
    .if_pc(o_pc[1]), .if_pc4(o_pc4[1]), .if_inst(o_inst[1]), .if_valid(o_valid[1]),
    .flush(o_flush[1]), .misalign_err(o_err[1]), .fetch_count(o_cnt[1]));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: PC, "still booting" flag, bubble cycles still owed, error flag, issue count
  logic [31:0] m_pc  [2];
  bit          m_boot[2];
  int          m_rem [2];
  bit          m_err [2];
  logic [31:0] m_cnt [2];

  function automatic int fc_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic bit m_flush(input int i);
    return redirect_valid || (m_rem[i] > 0);
  endfunction

  function automatic bit m_valid(input int i);
    return !m_boot[i] && !m_flush(i);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 32'h0; m_boot[i] = 1; m_rem[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < 2; i++) begin
      logic [31:0] e_inst;
      logic [AW-1:0] e_addr;
      e_addr = AW'(m_pc[i] >> 2);
      e_inst = m_valid(i) ? inst_of(e_addr) : 32'h0000_0033;
      chk($sformatf("m%0d_pc", i),    o_pc[i],   m_pc[i]);
      chk($sformatf("m%0d_pc4", i),   o_pc4[i],  m_pc[i] + 32'd4);
      chk($sformatf("m%0d_addr", i),  32'(o_addr[i]), 32'(e_addr));
      chk($sformatf("m%0d_inst", i),  o_inst[i], e_inst);
      chk($sformatf("m%0d_valid", i), 32'(o_valid[i]), 32'(m_valid(i)));
      chk($sformatf("m%0d_flush", i), 32'(o_flush[i]), 32'(m_flush(i)));
      chk($sformatf("m%0d_err", i),   32'(o_err[i]),   32'(m_err[i]));
      chk($sformatf("m%0d_cnt", i),   o_cnt[i],  m_cnt[i]);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit v;
      v = m_valid(i);
      if (!rst_n) begin
        m_pc[i] = 32'h0; m_boot[i] = 1; m_rem[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
      end else begin
        if (v && !stall && m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 1;
        if (redirect_valid) begin
          m_pc[i]   = redirect_pc & ~32'd3;
          m_err[i]  = m_err[i] || (redirect_pc[1:0] != 0);
          m_rem[i]  = fc_of(i) - 1;
          m_boot[i] = 0;
        end else if (m_rem[i] > 0) begin
          m_rem[i]--;
        end else if (m_boot[i]) begin
          m_boot[i] = 0;
        end else if (!stall) begin
          m_pc[i] = m_pc[i] + 32'd4;
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit s, input bit v, input logic [31:0] t);
    rst_n = r; stall = s; redirect_valid = v; redirect_pc = t;
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge ram_clk);
    model_step();
    @(negedge ram_clk);
  endtask

  typedef struct {
    bit          rst_n, stall, rv;
    logic [31:0] rpc;
    logic [31:0] e_pc;
    bit          e_flush, e_valid, e_err;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit s, input bit v, input logic [31:0] t,
                     input logic [31:0] p, input bit f, input bit va, input bit e,
                     input logic [31:0] c);
    vec_t x;
    x.rst_n = r; x.stall = s; x.rv = v; x.rpc = t;
    x.e_pc = p; x.e_flush = f; x.e_valid = va; x.e_err = e; x.e_cnt = c;
    vecs.push_back(x);
  endtask

  initial begin
    // Directed table for the FLUSH_CYCLES=3 instance; outputs seen before each edge
    add(0,0,0,0,      32'h00,  0,0,0, 0);
    add(1,0,0,0,      32'h00,  0,0,0, 0);
    add(1,0,0,0,      32'h00,  0,1,0, 0);
    add(1,0,0,0,      32'h04,  0,1,0, 1);
    add(1,0,0,0,      32'h08,  0,1,0, 2);
    add(1,0,0,0,      32'h0C,  0,1,0, 3);
    add(1,1,0,0,      32'h10,  0,1,0, 4);
    add(1,1,0,0,      32'h10,  0,1,0, 4);
    add(1,1,0,0,      32'h10,  0,1,0, 4);
    add(1,0,0,0,      32'h10,  0,1,0, 4);
    add(1,0,0,0,      32'h14,  0,1,0, 5);
    add(1,0,0,0,      32'h18,  0,1,0, 6);
    add(1,0,0,0,      32'h1C,  0,1,0, 7);
    add(1,1,1,32'h40, 32'h20,  1,0,0, 8);
    add(1,1,0,0,      32'h40,  1,0,0, 8);
    add(1,1,0,0,      32'h40,  1,0,0, 8);
    add(1,0,0,0,      32'h40,  0,1,0, 8);
    add(1,0,1,32'h60, 32'h44,  1,0,0, 9);
    add(1,0,1,32'h80, 32'h60,  1,0,0, 9);
    add(1,0,0,0,      32'h80,  1,0,0, 9);
    add(1,0,0,0,      32'h80,  1,0,0, 9);
    add(1,0,0,0,      32'h80,  0,1,0, 9);
    add(1,0,1,32'h106,32'h84,  1,0,0, 10);
    add(1,0,0,0,      32'h104, 1,0,1, 10);
    add(1,0,0,0,      32'h104, 1,0,1, 10);
    add(1,0,0,0,      32'h104, 0,1,1, 10);
    add(1,0,1,32'h200,32'h108, 1,0,1, 11);
    add(1,0,0,0,      32'h200, 1,0,1, 11);
    add(0,0,0,0,      32'h200, 1,0,1, 11);
    add(0,0,0,0,      32'h00,  0,0,0, 0);
    add(1,0,1,32'h300,32'h00,  1,0,0, 0);
    add(1,0,0,0,      32'h300, 1,0,0, 0);
    add(1,0,0,0,      32'h300, 1,0,0, 0);
    add(1,0,0,0,      32'h300, 0,1,0, 0);
    add(1,0,0,0,      32'h304, 0,1,0, 1);

    rst_n = 0; stall = 0; redirect_valid = 0; redirect_pc = 0;
    repeat (2) @(posedge ram_clk);
    @(negedge ram_clk);
    model_reset();

    foreach (vecs[k]) begin
      drive(vecs[k].rst_n, vecs[k].stall, vecs[k].rv, vecs[k].rpc);
      chk($sformatf("v%0d_pc", k),    o_pc[1],          vecs[k].e_pc);
      chk($sformatf("v%0d_flush", k), 32'(o_flush[1]),  32'(vecs[k].e_flush));
      chk($sformatf("v%0d_valid", k), 32'(o_valid[1]),  32'(vecs[k].e_valid));
      chk($sformatf("v%0d_err", k),   32'(o_err[1]),    32'(vecs[k].e_err));
      chk($sformatf("v%0d_cnt", k),   o_cnt[1],         vecs[k].e_cnt);
      tick();
    end

    // Single-cycle flush: redirect at pc 0x20, then PC wrap at the top of the address space
    drive(0, 0, 0, 0); tick();
    for (int n = 0; n < 9; n++) begin drive(1, 0, 0, 0); tick(); end
    drive(1, 0, 1, 32'h100);
    chk("fc1_redir_pc", o_pc[0], 32'h20);
    chk("fc1_redir_flush", 32'(o_flush[0]), 32'd1);
    chk("fc1_redir_valid", 32'(o_valid[0]), 32'd0);
    tick();
    drive(1, 0, 0, 0);
    chk("fc1_tgt_pc", o_pc[0], 32'h100);
    chk("fc1_tgt_flush", 32'(o_flush[0]), 32'd0);
    chk("fc1_tgt_valid", 32'(o_valid[0]), 32'd1);
    tick();
    drive(1, 0, 1, 32'hFFFF_FFFC); tick();
    drive(1, 0, 0, 0);
    chk("wrap_pc", o_pc[0], 32'hFFFF_FFFC);
    chk("wrap_pc4", o_pc4[0], 32'h0);
    chk("wrap_addr", 32'(o_addr[0]), 32'h3FF);
    tick();
    drive(1, 0, 0, 0);
    chk("wrap_next_pc", o_pc[0], 32'h0);
    chk("wrap_next_addr", 32'(o_addr[0]), 32'h0);
    tick();

    // Random traffic, including aliased high targets and misaligned ones
    for (int n = 0; n < 3000; n++) begin
      bit r, s, v;
      logic [31:0] t;
      r = ($urandom_range(0, 99) != 0);
      s = ($urandom_range(0, 99) < 30);
      v = ($urandom_range(0, 99) < 10);
      t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                      : $urandom();
      drive(r, s, v, t);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
